// File: rtl/debouncer_multi.sv
// debouncer_multi: multi-channel pushbutton debouncer with lockout.
//
// Each channel synchronises its raw pad input, then a small FSM emits one
// single-cycle press pulse per accepted press and holds a debounced level
// while the channel is locked out. MODE 0 re-fires every LOCKOUT+1 cycles
// while the button is held. MODE 1 fires once per press and needs LOCKOUT
// consecutive low samples before it will accept another press.
//
// Ports:
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   pb_in      raw asynchronous button inputs, active-high
//   chan_en    per-channel enable (synchronous); 0 forces the channel idle
//   pb_pulse   registered one-cycle press pulse per channel
//   pb_level   registered debounced level (1 while channel is not idle)
//   any_pulse  registered OR of the press pulses, same cycle as pb_pulse

// debouncer_chan: one channel (synchroniser + lockout FSM + counter).
//
// Ports:
//   clock, reset_n  as above
//   pb_in           raw pad input for this channel
//   chan_en         channel enable
//   pulse_nxt       combinational "pulse on the next edge", used for any_pulse
//   pb_pulse        registered press pulse
//   pb_level        registered debounced level
module debouncer_chan #(
   parameter int COUNT_WIDTH = 32,
   parameter int LOCKOUT     = 50000000,
   parameter int SYNC_STAGES = 2,
   parameter int MODE        = 0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic pb_in,
   input  logic chan_en,
   output logic pulse_nxt,
   output logic pb_pulse,
   output logic pb_level
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      REL_WAIT = 2'd2
   } state_t;

   // Terminal count: the counter never goes beyond LOCKOUT-1, so it can't wrap.
   localparam logic [COUNT_WIDTH-1:0] CNT_LAST  = COUNT_WIDTH'(LOCKOUT - 1);
   localparam state_t                 HOLD_EXIT = (MODE == 1) ? REL_WAIT : IDLE;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

   // Synchroniser runs regardless of chan_en so re-enabling sees a settled value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], pb_in};
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pulse_nxt = 1'b0;
      if (!chan_en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (s) begin
                  state_d   = HOLD;
                  pulse_nxt = 1'b1;
               end
            end
            // Input is ignored here: bounces during lockout never pulse.
            HOLD: begin
               if (cnt_q == CNT_LAST) begin
                  state_d = HOLD_EXIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + COUNT_WIDTH'(1);
               end
            end
            // Any high sample restarts the release window.
            REL_WAIT: begin
               if (s) begin
                  cnt_d = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + COUNT_WIDTH'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pb_pulse <= 1'b0;
         pb_level <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pb_pulse <= pulse_nxt;
         pb_level <= (state_d != IDLE);
      end
   end

endmodule

module debouncer_multi #(
   parameter int CHANNELS    = 4,
   parameter int COUNT_WIDTH = 32,
   parameter int LOCKOUT     = 50000000,
   parameter int SYNC_STAGES = 2,
   parameter int MODE        = 0
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] pb_in,
   input  logic [CHANNELS-1:0] chan_en,
   output logic [CHANNELS-1:0] pb_pulse,
   output logic [CHANNELS-1:0] pb_level,
   output logic                any_pulse
);

   logic [CHANNELS-1:0] pulse_nxt;

   debouncer_chan #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .LOCKOUT     (LOCKOUT),
      .SYNC_STAGES (SYNC_STAGES),
      .MODE        (MODE)
   ) u_chan [CHANNELS-1:0] (
      .clock     (clock),
      .reset_n   (reset_n),
      .pb_in     (pb_in),
      .chan_en   (chan_en),
      .pulse_nxt (pulse_nxt),
      .pb_pulse  (pb_pulse),
      .pb_level  (pb_level)
   );

   // Registered from the same next-cycle terms as pb_pulse so it lines up exactly.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) any_pulse <= 1'b0;
      else          any_pulse <= |pulse_nxt;
   end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: one REPEAT and one ONESHOT instance share the
// same inputs; a time-based reference model predicts every output each cycle,
// plus fixed expectations for the hand-worked scenarios.
module tb_debouncer_multi;
   localparam int CH = 4;
   localparam int L  = 5;
   localparam int SS = 2;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b1;
   logic [CH-1:0] pb_in   = '0;
   logic [CH-1:0] chan_en = '1;
   logic [CH-1:0] pulse0, level0, pulse1, level1;
   logic          any0, any1;

   int n_chk = 0;
   int n_bad = 0;

   // model: act = channel locked out, t0 = edge of accepted press,
   // lows = consecutive low samples counted during release
   bit            act  [2][CH];
   int            t0   [2][CH];
   int            lows [2][CH];
   int            edge_n = 0;
   logic [CH-1:0] ep [2];
   logic [CH-1:0] el [2];
   logic [CH-1:0] dq [$];

   always #5 clock = ~clock;

   debouncer_multi #(.CHANNELS(CH), .COUNT_WIDTH(8), .LOCKOUT(L), .SYNC_STAGES(SS), .MODE(0)) dut0 (
      .clock(clock), .reset_n(reset_n), .pb_in(pb_in), .chan_en(chan_en),
      .pb_pulse(pulse0), .pb_level(level0), .any_pulse(any0));

   debouncer_multi #(.CHANNELS(CH), .COUNT_WIDTH(8), .LOCKOUT(L), .SYNC_STAGES(SS), .MODE(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .pb_in(pb_in), .chan_en(chan_en),
      .pb_pulse(pulse1), .pb_level(level1), .any_pulse(any1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < CH; c++) begin
            act[m][c]  = 1'b0;
            t0[m][c]   = 0;
            lows[m][c] = 0;
         end
         ep[m] = '0;
         el[m] = '0;
      end
      dq.delete();
      repeat (SS) dq.push_back('0);
   endtask

   // The FSM at edge n sees the pad value that was present SS edges earlier.
   task automatic model_edge(input logic [CH-1:0] pin, input logic [CH-1:0] en);
      logic [CH-1:0] s;
      s = dq.pop_front();
      dq.push_back(pin);
      edge_n++;
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < CH; c++) begin
            ep[m][c] = 1'b0;
            if (!en[c]) begin
               act[m][c] = 1'b0;
            end else if (!act[m][c]) begin
               if (s[c]) begin
                  ep[m][c]   = 1'b1;
                  act[m][c]  = 1'b1;
                  t0[m][c]   = edge_n;
                  lows[m][c] = 0;
               end
            end else if (edge_n - t0[m][c] < L) begin
               // still within the lockout window
            end else if (m == 0) begin
               act[m][c] = 1'b0;
            end else if (edge_n - t0[m][c] > L) begin
               lows[m][c] = s[c] ? 0 : lows[m][c] + 1;
               if (lows[m][c] == L) act[m][c] = 1'b0;
            end
            el[m][c] = act[m][c];
         end
      end
   endtask

   task automatic step();
      logic [CH-1:0] pin, en;
      @(posedge clock);
      pin = pb_in;
      en  = chan_en;
      #1;
      if (reset_n) model_edge(pin, en);
      chk("pulse0", 32'(pulse0), 32'(ep[0]));
      chk("level0", 32'(level0), 32'(el[0]));
      chk("any0",   32'(any0),   32'(|ep[0]));
      chk("pulse1", 32'(pulse1), 32'(ep[1]));
      chk("level1", 32'(level1), 32'(el[1]));
      chk("any1",   32'(any1),   32'(|ep[1]));
   endtask

   // Assert reset between edges, check outputs clear at once, release mid-cycle.
   task automatic do_reset();
      #3 reset_n = 1'b0;
      model_reset();
      #1 chk("rst_async", 32'({pulse0, level0, any0, pulse1, level1, any1}), 32'd0);
      step();
      step();
      #2 reset_n = 1'b1;
   endtask

   initial begin
      do_reset();

      // held button: REPEAT on ch0, ONESHOT on ch1 (ch1 released after edge 20)
      step();
      pb_in = 4'b0011;
      for (int k = 1; k <= 30; k++) begin
         step();
         chk("rep_pulse", 32'(pulse0[0]), 32'(k >= 3 && (k - 3) % 6 == 0));
         chk("rep_level", 32'(level0[0]), 32'(k >= 3 && (k - 3) % 6 != 5));
         chk("one_pulse", 32'(pulse1[1]), 32'(k == 3));
         chk("one_level", 32'(level1[1]), 32'(k >= 3 && k <= 26));
         if (k == 20) pb_in[1] = 1'b0;
      end

      // bounces on ch2 during HOLD and REL_WAIT
      pb_in = '0;
      do_reset();
      step();
      pb_in[2] = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (k >= 4 && k <= 8)   pb_in[2] = ~pb_in[2];
         if (k >= 12 && k <= 16) pb_in[2] = k[0];
         if (k == 17)            pb_in[2] = 1'b0;
      end

      // simultaneous press on ch0/ch3, enable drop mid-HOLD, reset mid-HOLD
      pb_in = '0;
      do_reset();
      step();
      pb_in = 4'b1001;
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k == 3) begin
            chk("sim_pulse", 32'(pulse0), 32'h9);
            chk("sim_any",   32'(any0),   32'd1);
         end
         if (k == 4) begin
            chk("sim_pulse_end", 32'(pulse0), 32'h0);
            chk("sim_any_end",   32'(any0),   32'd0);
         end
         if (k == 5) chan_en[0] = 1'b0;
         if (k == 6) begin
            chk("en_off_level", 32'(level0[0]), 32'd0);
            chan_en[0] = 1'b1;
         end
         if (k == 7) chk("en_on_pulse", 32'(pulse0[0]), 32'd1);
      end
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("rst_rel_pulse", 32'(pulse0), (k == 3) ? 32'h9 : 32'h0);
      end

      // randomized traffic: bouncy first, then longer holds
      for (int i = 0; i < 2500; i++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, (i < 1200) ? 2 : 11) == 0) pb_in[c] = ~pb_in[c];
            if (chan_en[c] ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 9) == 0))
               chan_en[c] = ~chan_en[c];
         end
         step();
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
